// File: rtl/ex_stage_if.sv
// Execute-stage bus: ID/EX latch side (operands, controls) and memory-stage side
// (registered results), plus the stall fed back upstream.
interface ex_stage_if #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] readData0;
    logic [DATA_W-1:0] readData1;
    logic [OP_W-1:0]   ALUOp;
    logic              ReadMem;
    logic              WriteMem;
    logic [DATA_W-1:0] DataIn;
    logic [1:0]        quarter;
    logic              write;

    logic              stall;
    logic              o_valid;
    logic [DATA_W-1:0] o_ALUResult;
    logic              o_zero;
    logic              o_ReadMem;
    logic              o_WriteMem;
    logic              o_write;
    logic [DATA_W-1:0] o_DataIn;
    logic [1:0]        o_quarter;

    // Upstream pipeline / downstream consumer view.
    modport master (
        output in_valid, readData0, readData1, ALUOp, ReadMem, WriteMem, DataIn, quarter, write,
        input  stall, o_valid, o_ALUResult, o_zero, o_ReadMem, o_WriteMem, o_write, o_DataIn, o_quarter
    );

    // Execute-stage view.
    modport slave (
        input  in_valid, readData0, readData1, ALUOp, ReadMem, WriteMem, DataIn, quarter, write,
        output stall, o_valid, o_ALUResult, o_zero, o_ReadMem, o_WriteMem, o_write, o_DataIn, o_quarter
    );
endinterface

// File: rtl/ex_stage_unit.sv
// Execute stage: single-cycle ALU plus a DATA_W-cycle shift-add multiplier that
// stalls the ID/EX latch while it iterates. All outputs are registered.
module ex_stage_unit #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 4
) (
    input logic       clk,
    input logic       rst_n,
    ex_stage_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_NOT   = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(4'h9);
    localparam logic [OP_W-1:0] OP_MUL   = OP_W'(4'hA);
    localparam logic [OP_W-1:0] OP_PASSA = OP_W'(4'hB);
    localparam logic [OP_W-1:0] OP_PASSB = OP_W'(4'hC);

    typedef enum logic {IDLE, MUL} stateT;

    stateT             state, stateNext;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mulA, mulB, acc, mulSum;
    logic [DATA_W-1:0] aluResult;
    logic [3:0]        shamt;
    logic              mulAccept;

    // Pass-through fields captured at multiply accept, released with the product.
    logic              capReadMem, capWriteMem, capWrite;
    logic [DATA_W-1:0] capDataIn;
    logic [1:0]        capQuarter;

    logic              validQ, zeroQ, readMemQ, writeMemQ, writeQ;
    logic [DATA_W-1:0] resultQ, dataInQ;
    logic [1:0]        quarterQ;

    assign shamt     = bus.readData1[3:0];
    assign mulAccept = (state == IDLE) && bus.in_valid && (bus.ALUOp == OP_MUL);
    assign mulSum    = acc + (mulB[0] ? mulA : '0);
    assign bus.stall = (state == MUL) || mulAccept;

    // Single-cycle ALU result for the operation currently offered by ID/EX.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        aluResult = '0;
        case (bus.ALUOp)
            OP_ADD:   aluResult = bus.readData0 + bus.readData1;
            OP_SUB:   aluResult = bus.readData0 - bus.readData1;
            OP_AND:   aluResult = bus.readData0 & bus.readData1;
            OP_OR:    aluResult = bus.readData0 | bus.readData1;
            OP_XOR:   aluResult = bus.readData0 ^ bus.readData1;
            OP_NOT:   aluResult = ~bus.readData0;
            OP_SLL:   aluResult = bus.readData0 << shamt;
            OP_SRL:   aluResult = bus.readData0 >> shamt;
            OP_SRA:   aluResult = $signed(bus.readData0) >>> shamt;
            OP_SLT:   aluResult = DATA_W'($signed(bus.readData0) < $signed(bus.readData1));
            OP_PASSA: aluResult = bus.readData0;
            OP_PASSB: aluResult = bus.readData1;
            default:  aluResult = '0;
        endcase
    end

    // Next state: enter MUL on accept, leave after the last iteration.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (mulAccept) stateNext = MUL;
            MUL:     if (count == CNT_LAST) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State, multiplier datapath and registered outputs to the memory stage.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            mulA        <= '0;
            mulB        <= '0;
            acc         <= '0;
            capReadMem  <= 1'b0;
            capWriteMem <= 1'b0;
            capWrite    <= 1'b0;
            capDataIn   <= '0;
            capQuarter  <= '0;
            validQ      <= 1'b0;
            resultQ     <= '0;
            zeroQ       <= 1'b1;
            readMemQ    <= 1'b0;
            writeMemQ   <= 1'b0;
            writeQ      <= 1'b0;
            dataInQ     <= '0;
            quarterQ    <= '0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (mulAccept) begin
                        mulA        <= bus.readData0;
                        mulB        <= bus.readData1;
                        acc         <= '0;
                        count       <= '0;
                        capReadMem  <= bus.ReadMem;
                        capWriteMem <= bus.WriteMem;
                        capWrite    <= bus.write;
                        capDataIn   <= bus.DataIn;
                        capQuarter  <= bus.quarter;
                        validQ      <= 1'b0;
                        readMemQ    <= 1'b0;
                        writeMemQ   <= 1'b0;
                        writeQ      <= 1'b0;
                    end else if (bus.in_valid) begin
                        validQ    <= 1'b1;
                        resultQ   <= aluResult;
                        zeroQ     <= (aluResult == '0);
                        readMemQ  <= bus.ReadMem;
                        writeMemQ <= bus.WriteMem;
                        writeQ    <= bus.write;
                        dataInQ   <= bus.DataIn;
                        quarterQ  <= bus.quarter;
                    end else begin
                        // Bubble: drop the qualifiers, keep the data fields.
                        validQ    <= 1'b0;
                        readMemQ  <= 1'b0;
                        writeMemQ <= 1'b0;
                        writeQ    <= 1'b0;
                    end
                end
                MUL: begin
                    acc   <= mulSum;
                    mulA  <= mulA << 1;
                    mulB  <= mulB >> 1;
                    count <= count + 1'b1;
                    if (count == CNT_LAST) begin
                        validQ    <= 1'b1;
                        resultQ   <= mulSum;
                        zeroQ     <= (mulSum == '0);
                        readMemQ  <= capReadMem;
                        writeMemQ <= capWriteMem;
                        writeQ    <= capWrite;
                        dataInQ   <= capDataIn;
                        quarterQ  <= capQuarter;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_valid     = validQ;
    assign bus.o_ALUResult = resultQ;
    assign bus.o_zero      = zeroQ;
    assign bus.o_ReadMem   = readMemQ;
    assign bus.o_WriteMem  = writeMemQ;
    assign bus.o_write     = writeQ;
    assign bus.o_DataIn    = dataInQ;
    assign bus.o_quarter   = quarterQ;
endmodule

// File: tb/tb_ex_stage_unit.sv
// Randomised self-checking bench for ex_stage_unit against an arithmetic reference model.
module tb_ex_stage_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passCount = 0;
    int   checkCount = 0;

    logic [15:0] expRes = '0;
    logic [15:0] expDin = '0;
    logic [1:0]  expQ = '0;

    ex_stage_if #(.DATA_W(16), .OP_W(4)) bus ();

    ex_stage_unit #(.DATA_W(16), .OP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Reference: result of each opcode from plain integer arithmetic.
    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int          sa, sb, s;
        longint      p;
        logic [31:0] r;
        sa = (a >= 16'h8000) ? int'(a) - 65536 : int'(a);
        sb = (b >= 16'h8000) ? int'(b) - 65536 : int'(b);
        s  = int'(b) % 16;
        p  = longint'(a) * longint'(b);
        case (op)
            4'd0:    r = 32'(int'(a) + int'(b));
            4'd1:    r = 32'(int'(a) - int'(b));
            4'd2:    r = 32'(a & b);
            4'd3:    r = 32'(a | b);
            4'd4:    r = 32'(a ^ b);
            4'd5:    r = 32'(65535 - int'(a));
            4'd6:    r = 32'(int'(a) * (1 << s));
            4'd7:    r = 32'(int'(a) / (1 << s));
            4'd8:    r = 32'(sa >>> s);
            4'd9:    r = (sa < sb) ? 32'd1 : 32'd0;
            4'd10:   r = 32'(p % 65536);
            4'd11:   r = 32'(a);
            4'd12:   r = 32'(b);
            default: r = 32'd0;
        endcase
        return r[15:0];
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic rm, input logic wm, input logic [15:0] din, input logic [1:0] q,
                         input logic wr);
        bus.in_valid  = v;
        bus.ALUOp     = op;
        bus.readData0 = a;
        bus.readData1 = b;
        bus.ReadMem   = rm;
        bus.WriteMem  = wm;
        bus.DataIn    = din;
        bus.quarter   = q;
        bus.write     = wr;
    endtask

    task automatic driveRandom();
        drive(1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              16'($urandom), 2'($urandom), 1'($urandom));
    endtask

    task automatic checkOutputs(input string tag, input logic v, input logic rm, input logic wm,
                                input logic wr);
        check({tag, "_valid"}, bus.o_valid, v);
        check({tag, "_result"}, bus.o_ALUResult, expRes);
        check({tag, "_zero"}, bus.o_zero, expRes == 16'h0);
        check({tag, "_readmem"}, bus.o_ReadMem, rm);
        check({tag, "_writemem"}, bus.o_WriteMem, wm);
        check({tag, "_write"}, bus.o_write, wr);
        check({tag, "_datain"}, bus.o_DataIn, expDin);
        check({tag, "_quarter"}, bus.o_quarter, expQ);
    endtask

    // Called at posedge+1; completes at posedge+1 of the following cycle.
    task automatic singleOp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic rm, input logic wm, input logic [15:0] din,
                            input logic [1:0] q, input logic wr);
        drive(1'b1, op, a, b, rm, wm, din, q, wr);
        #1 check("single_stall", bus.stall, 1'b0);
        @(posedge clk); #1;
        expRes = model(op, a, b);
        expDin = din;
        expQ   = q;
        checkOutputs($sformatf("op%0h", op), 1'b1, rm, wm, wr);
    endtask

    task automatic bubble();
        drive(1'b0, 4'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1, 16'($urandom), 2'($urandom), 1'b1);
        #1 check("bubble_stall", bus.stall, 1'b0);
        @(posedge clk); #1;
        checkOutputs("bubble", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mulOp(input logic [15:0] a, input logic [15:0] b, input logic scramble, input logic chain);
        logic        rm, wm, wr;
        logic [15:0] din;
        logic [1:0]  q;
        rm  = 1'($urandom);
        wm  = 1'($urandom);
        wr  = 1'($urandom);
        din = 16'($urandom);
        q   = 2'($urandom);
        drive(1'b1, 4'hA, a, b, rm, wm, din, q, wr);
        #1 check("mul_stall_accept", bus.stall, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (scramble) driveRandom();
            #1;
            check($sformatf("mul_stall_c%0d", i), bus.stall, 1'b1);
            check($sformatf("mul_valid_c%0d", i), bus.o_valid, 1'b0);
            check($sformatf("mul_ctl_c%0d", i), {bus.o_ReadMem, bus.o_WriteMem, bus.o_write}, 3'b000);
        end
        @(posedge clk); #1;
        expRes = model(4'hA, a, b);
        expDin = din;
        expQ   = q;
        checkOutputs("mul_done", 1'b1, rm, wm, wr);
        if (!chain) begin
            bus.in_valid = 1'b0;
            #1 check("mul_done_stall", bus.stall, 1'b0);
        end
    endtask

    task automatic checkReset(input string tag);
        expRes = '0;
        expDin = '0;
        expQ   = '0;
        checkOutputs(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        check({tag, "_stall"}, bus.stall, 1'b0);
    endtask

    initial begin
        logic [3:0] op;
        drive(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 2'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 checkReset("reset_initial");
        rst_n = 1'b1;

        // Warm up, then reset mid-stream with a live instruction presented.
        singleOp(4'h0, 16'h1234, 16'h1111, 1'b1, 1'b0, 16'hCAFE, 2'd3, 1'b1);
        rst_n = 1'b0;
        drive(1'b1, 4'h0, 16'h5555, 16'h1111, 1'b1, 1'b1, 16'h1234, 2'd1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #1 checkReset("reset_mid");
        rst_n = 1'b1;

        singleOp(4'h0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        singleOp(4'h1, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        singleOp(4'h8, 16'h8000, 16'h0004, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        singleOp(4'h6, 16'h0001, 16'h000F, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        singleOp(4'h9, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        singleOp(4'h4, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        singleOp(4'h0, 16'h0010, 16'h0020, 1'b1, 1'b0, 16'hBEEF, 2'd2, 1'b1);
        bubble();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) bubble();
            else begin
                op = 4'($urandom);
                if (op == 4'hA) op = 4'hB;
                singleOp(op, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                         16'($urandom), 2'($urandom), 1'($urandom));
            end
        end

        mulOp(16'h0123, 16'h0045, 1'b0, 1'b0);
        mulOp(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        mulOp(16'($urandom), 16'($urandom), 1'b1, 1'b1);
        mulOp(16'h0100, 16'h0100, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) mulOp(16'($urandom), 16'($urandom), 1'b1, 1'b0);
        singleOp(4'h3, 16'h00F0, 16'h0F00, 1'b0, 1'b1, 16'h1357, 2'd1, 1'b0);

        // Reset during a multiply: discarded, no product ever appears.
        drive(1'b1, 4'hA, 16'h0123, 16'h0045, 1'b1, 1'b1, 16'h2468, 2'd2, 1'b1);
        #1 check("rmul_stall_accept", bus.stall, 1'b1);
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checkReset("rmul_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check($sformatf("rmul_quiet_valid_%0d", i), bus.o_valid, 1'b0);
            check($sformatf("rmul_quiet_stall_%0d", i), bus.stall, 1'b0);
        end
        singleOp(4'h0, 16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0, 2'd0, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
